// File: rtl/chrom_pkg.sv
// Shared definitions for the chromosome loader: default chromosome geometry,
// loader FSM states and the error byte returned on a failed checksum.
package chrom_pkg;

    localparam int         CHROM_BITS = 103;
    localparam int         NBYTES     = (CHROM_BITS + 7) / 8;
    localparam logic [7:0] ERR_BYTE   = 8'hFF;

    typedef enum logic [1:0] {
        RECV,
        APPLY,
        EVAL,
        SEND
    } state_t;

endpackage

// File: rtl/sequenciador_avaliacao.sv
// Evaluation sequencer: sweeps every input combination, holds each for SETTLE_CYCLES
// and captures the circuit response on the last cycle of each window.
module sequenciador_avaliacao #(
    parameter int N_IN          = 2,
    parameter int N_OUT         = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int TT_BITS       = (1 << N_IN) * N_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_OUT-1:0]   chrom_out,
    output logic [N_IN-1:0]    chrom_in,
    output logic [TT_BITS-1:0] tabela,
    output logic               done
);

    localparam int NCOMB = 1 << N_IN;
    localparam int CW    = $clog2(SETTLE_CYCLES + 1);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [TT_BITS-1:0] tt;
    logic               last_tick;

    assign last_tick = busy && (cnt == CW'(SETTLE_CYCLES - 1));
    // done is combinational so the caller leaves EVAL on the very edge of the last sample
    assign done      = last_tick && (chrom_in == '1);

    // tabela is the table with the current response merged in, valid on last_tick
    always_comb begin
        tabela = tt;
        for (int c = 0; c < NCOMB; c++) begin
            if (chrom_in == N_IN'(c)) tabela[c*N_OUT +: N_OUT] = chrom_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            chrom_in <= '0;
            tt       <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            chrom_in <= '0;
            tt       <= '0;
        end else if (busy) begin
            if (last_tick) begin
                tt       <= tabela;
                cnt      <= '0;
                chrom_in <= chrom_in + 1'b1;
                if (done) busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/carregador_cromossomo.sv
// Chromosome loader/evaluator: assembles host bytes into the chromosome, sweeps the circuit
// and returns its truth table. Define CHROM_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state | meaning
// RECV  | accepting chromosome bytes into the shadow register
// APPLY | one cycle: shadow copied to cromossomo, sequencer started
// EVAL  | sequencer sweeping input combinations
// SEND  | result byte offered to host until tx_ready
module carregador_cromossomo #(
    parameter int CHROM_BITS    = chrom_pkg::CHROM_BITS,
    parameter int N_IN          = 2,
    parameter int N_OUT         = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [CHROM_BITS-1:0] cromossomo,
    output logic                  processing,
    output logic [N_IN-1:0]       chromIn,
    input  logic [N_OUT-1:0]      chromOut
);

    import chrom_pkg::*;

    localparam int NB      = (CHROM_BITS + 7) / 8;
`ifdef CHROM_CHECKSUM_EN
    localparam int NB_RX   = NB + 1;
`else
    localparam int NB_RX   = NB;
`endif
    localparam int BCW     = $clog2(NB_RX + 1);
    localparam int TT_BITS = (1 << N_IN) * N_OUT;

    localparam logic [BCW-1:0] LAST_IDX = BCW'(NB_RX - 1);
    localparam logic [BCW-1:0] NB_IDX   = BCW'(NB);

    state_t             state;
    logic [NB*8-1:0]    shadow;
    logic [BCW-1:0]     byte_cnt;
    logic [TT_BITS-1:0] tabela;
    logic               eval_start;
    logic               eval_done;
    logic               unused_pad;
`ifdef CHROM_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // padding bits of the last byte never reach the phenotype
    assign unused_pad = ^shadow[NB*8-1:CHROM_BITS];
    assign eval_start = (state == APPLY);

    sequenciador_avaliacao #(
        .N_IN          (N_IN),
        .N_OUT         (N_OUT),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (eval_start),
        .chrom_out (chromOut),
        .chrom_in  (chromIn),
        .tabela    (tabela),
        .done      (eval_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RECV;
            shadow     <= '0;
            byte_cnt   <= '0;
            cromossomo <= '0;
            rx_ready   <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            processing <= 1'b0;
`ifdef CHROM_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                RECV: begin
                    rx_ready <= 1'b1;
                    if (rx_valid && rx_ready) begin
                        if (byte_cnt < NB_IDX) shadow[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef CHROM_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_cnt == LAST_IDX) begin
                            rx_ready <= 1'b0;
`ifdef CHROM_CHECKSUM_EN
                            // on a bad checksum the applied chromosome is left untouched
                            if (csum != rx_data) begin
                                state    <= SEND;
                                tx_valid <= 1'b1;
                                tx_data  <= ERR_BYTE;
                            end else begin
                                state      <= APPLY;
                                processing <= 1'b1;
                            end
`else
                            state      <= APPLY;
                            processing <= 1'b1;
`endif
                        end
                    end
                end
                APPLY: begin
                    cromossomo <= shadow[CHROM_BITS-1:0];
                    state      <= EVAL;
                end
                EVAL: begin
                    if (eval_done) begin
                        processing <= 1'b0;
                        tx_valid   <= 1'b1;
                        tx_data    <= 8'(tabela);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        byte_cnt <= '0;
                        rx_ready <= 1'b1;
                        state    <= RECV;
`ifdef CHROM_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule
